// File: rtl/parity_tx_serializer.sv
// rtl/parity_tx_serializer.sv - nibble serializer: start, 4 data bits LSB first, parity, stop (optional 2nd stop via PARITY_TX_STOP2_EN)
module parity_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       odd_sel,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       parity,
  output logic       busy
);

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

`ifdef PARITY_TX_STOP2_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, STOP2} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

  state_t     state;
  logic [7:0] bit_cnt;
  logic [1:0] bit_idx;
  logic [1:0] next_idx;
  logic [3:0] data_reg;
  logic       bit_done;

  assign bit_done = (bit_cnt == CNT_MAX);
  assign next_idx = bit_idx + 2'd1;

  // Frame sequencer; every output is registered so tx_out already carries the
  // next bit value on the edge where the state advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 8'd0;
      bit_idx   <= 2'd0;
      data_reg  <= 4'd0;
      parity    <= 1'b0;
      tx_out    <= 1'b1;
      ready_out <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= 8'd0;
          if (valid_in) begin
            // Latch the nibble and its parity so later input changes cannot leak in.
            data_reg  <= D;
            parity    <= (^D) ^ odd_sel;
            bit_idx   <= 2'd0;
            state     <= START;
            tx_out    <= 1'b0;
            ready_out <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= 8'd0;
            bit_idx <= 2'd0;
            state   <= DATA;
            tx_out  <= data_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= 8'd0;
            bit_idx <= next_idx;
            if (bit_idx == 2'd3) begin
              state  <= PAR;
              tx_out <= parity;
            end else begin
              tx_out <= data_reg[next_idx];
            end
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        PAR: begin
          if (bit_done) begin
            bit_cnt <= 8'd0;
            state   <= STOP;
            tx_out  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= 8'd0;
`ifdef PARITY_TX_STOP2_EN
            state   <= STOP2;
            tx_out  <= 1'b1;
`else
            state     <= IDLE;
            tx_out    <= 1'b1;
            ready_out <= 1'b1;
            busy      <= 1'b0;
`endif
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
`ifdef PARITY_TX_STOP2_EN
        STOP2: begin
          if (bit_done) begin
            bit_cnt   <= 8'd0;
            state     <= IDLE;
            tx_out    <= 1'b1;
            ready_out <= 1'b1;
            busy      <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          bit_cnt   <= 8'd0;
          bit_idx   <= 2'd0;
          tx_out    <= 1'b1;
          ready_out <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/parity_tx_serializer.md
PARITY_TX_SERIALIZER -- requirements
Module: parity_tx_serializer

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port D, input, 4 bits: data nibble to transmit.
REQ-005 The module SHALL have port odd_sel, input, 1 bit: parity mode (0 = even, 1 = odd), sampled at acceptance.
REQ-006 The module SHALL have port valid_in, input, 1 bit: D and odd_sel are valid.
REQ-007 The module SHALL have port ready_out, output, 1 bit: the block can accept a nibble.
REQ-008 The module SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-009 The module SHALL have port parity, output, 1 bit: parity bit of the frame in flight (latched at acceptance).
REQ-010 The module SHALL have port busy, output, 1 bit: high while a frame is being transmitted.

Function
REQ-011 The module SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-012 The module SHALL accept a nibble on a rising edge with valid_in=1 and ready_out=1; ready_out SHALL be 1 only in IDLE, and valid_in SHALL be ignored outside IDLE.
REQ-013 On acceptance the module SHALL register D, and SHALL register parity = ^D when odd_sel=0 or ~^D when odd_sel=1, so that the ones-count of D plus parity is even or odd respectively.
REQ-014 The frame SHALL be: start bit 0, D[0], D[1], D[2], D[3] (LSB first), parity, stop bit 1, with each bit driven on tx_out for exactly CLKS_PER_BIT cycles.
REQ-015 tx_out SHALL be registered, and SHALL drive the start bit in the first cycle after the acceptance edge.
REQ-016 Transitions SHALL be: IDLE->START on acceptance; START->DATA, DATA->PAR (after the 4th data bit), PAR->STOP, and STOP->IDLE, each when the bit counter reaches CLKS_PER_BIT-1.
REQ-017 A 2-bit index SHALL select the data bit; it SHALL reset to 0 at START and wrap to PAR after index 3.
REQ-018 busy SHALL be 1 in every state except IDLE, and busy SHALL always equal ~ready_out.
REQ-019 The frame SHALL last 7*CLKS_PER_BIT cycles, with at least one IDLE cycle (tx_out=1, ready_out=1) between frames.
REQ-020 With valid_in held high, frames SHALL start every 7*CLKS_PER_BIT+1 cycles.
REQ-021 Changes on D and odd_sel after acceptance SHALL NOT affect the frame in flight.
REQ-022 With CLKS_PER_BIT=1, each bit SHALL occupy one cycle and the FSM SHALL advance every cycle.

Reset
REQ-023 When rst=1 at a rising edge, the module SHALL enter IDLE and clear the bit counter, the bit index and the data register.
REQ-024 During reset the outputs SHALL be tx_out=1, ready_out=1, busy=0, parity=0.
REQ-025 Reset SHALL take priority over acceptance; a nibble presented in a reset cycle SHALL be dropped.
REQ-026 Reset mid-frame SHALL abort the frame; tx_out SHALL be 1 from the next cycle, and no partial frame SHALL resume.

Configuration
REQ-027 With macro PARITY_TX_STOP2_EN defined, the module SHALL add a second stop bit (state STOP2, tx_out=1, CLKS_PER_BIT cycles) after STOP, giving a frame of 8*CLKS_PER_BIT cycles.
REQ-028 With PARITY_TX_STOP2_EN undefined, the module SHALL contain no STOP2 state and SHALL use a frame of 7*CLKS_PER_BIT cycles.

Verification
REQ-029 A bench SHALL cover: CLKS_PER_BIT=4, D=4'b1011, odd_sel=0 -> tx_out bits 0,1,1,0,1,1,1, each 4 cycles; parity=1.
REQ-030 A bench SHALL cover: D=4'b0000, odd_sel=1 -> parity=1; D=4'b0000, odd_sel=0 -> parity=0; the received frame passes an even/odd parity check respectively.
REQ-031 A bench SHALL cover: valid_in held high with nibbles 4'hA then 4'h5 -> two frames 29 cycles apart start-to-start; ready_out pulses for one cycle between them.
REQ-032 A bench SHALL cover: rst asserted in the 3rd data bit -> next cycle tx_out=1, busy=0, ready_out=1; a new nibble sends a complete, correct frame.
REQ-033 A bench SHALL cover: D toggled every cycle during a frame -> transmitted bits equal the nibble latched at acceptance.
REQ-034 A bench SHALL cover: PARITY_TX_STOP2_EN defined, CLKS_PER_BIT=1 -> frame 0,d0,d1,d2,d3,p,1,1, with ready_out returning on cycle 9 after acceptance.
